// File: rtl/cs_filter_seq_pkg.sv
// Shared types and constants for the CS smoothing filter: mode encoding, FSM states
// and the accumulator width rule.
package cs_filter_seq_pkg;

    localparam logic CS_MODE_APPR = 1'b0;
    localparam logic CS_MODE_AVG  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_SCAN,
        ST_CALC,
        ST_DONE
    } cs_state_e;

    // The running sum of n samples of w bits never exceeds this width.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/cs_filter_seq_if.sv
// Sample-in / result-out valid-ready bundle of the CS smoothing filter.
interface cs_filter_seq_if #(
    parameter int W     = 8,
    parameter int OUT_W = W + 2
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;

    modport master (
        output in_valid, x, mode, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, mode, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/cs_filter_seq_div.sv
// Restoring unsigned divider by a constant N: one quotient bit per cycle after a load cycle.
// done_o marks the cycle whose edge retires the last bit; quot_o is final from then on.
module cs_filter_seq_div
    import cs_filter_seq_pkg::*;
#(
    parameter int DW = 12,
    parameter int N  = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] quot_o
);
    localparam int RW = $clog2(N) + 1;
    localparam int CW = $clog2(DW + 1);
    localparam logic [RW:0] DIVISOR = (RW + 1)'(N);

    logic [RW-1:0] rem_q;
    logic [DW-1:0] quot_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [RW:0]   trial;
    logic          ge;

    // Dividend bits are shifted out of quot_q while quotient bits shift in behind them.
    assign trial = {rem_q, quot_q[DW-1]};
    assign ge    = (trial >= DIVISOR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i && !busy_q) begin
            rem_q  <= '0;
            quot_q <= dividend_i;
            cnt_q  <= CW'(DW);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= ge ? RW'(trial - DIVISOR) : trial[RW-1:0];
            quot_q <= {quot_q[DW-2:0], ge};
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign quot_o = quot_q;

endmodule

// File: rtl/cs_filter_seq.sv
// Sliding-window CS smoothing filter: avg by sequential divide, then a scan for the largest
// window sample not above avg, then either the CS approximation or the plain average.
//
//  state   | meaning
//  IDLE    | waiting for a sample, in_ready high
//  DIV     | load + SUM_W iterations of sum / N
//  SCAN    | one window tap per cycle, tracking xappr
//  CALC    | form and saturate the result into y
//  DONE    | out_valid high until out_ready
module cs_filter_seq
    import cs_filter_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3,
    parameter int OUT_W = W + 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    cs_filter_seq_if.slave  bus
);
    localparam int SUM_W = sum_width(W, N);
    localparam int IW    = $clog2(N);
    localparam int RES_W = SUM_W + 1;
    localparam logic [RES_W-1:0] N_R = RES_W'(N);

    cs_state_e        state_q;
    logic [W-1:0]     win_q [N];
    logic [SUM_W-1:0] sum_q;
    logic             mode_q;
    logic [IW-1:0]    idx_q;
    logic [W-1:0]     xappr_q;
    logic [OUT_W-1:0] y_q;
    logic             out_valid_q;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [SUM_W-1:0] avg;
    logic [W-1:0]     tap;
    logic [RES_W-1:0] res;
    logic [OUT_W-1:0] y_calc;

    assign div_start = (state_q == ST_DIV) && !div_busy;

    cs_filter_seq_div #(
        .DW (SUM_W),
        .N  (N)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .abort_i    (clear),
        .start_i    (div_start),
        .dividend_i (sum_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (avg)
    );

    assign tap = win_q[idx_q];

    always_comb begin
        res    = '0;
        y_calc = '0;
        if (mode_q == CS_MODE_AVG) begin
            res = RES_W'(avg);
        end else begin
            res = (RES_W'(sum_q) + N_R * RES_W'(xappr_q)) >> SHIFT;
        end
        if ((RES_W > OUT_W) && ((res >> OUT_W) != '0)) begin
            y_calc = '1;
        end else begin
            y_calc = OUT_W'(res);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            sum_q       <= '0;
            mode_q      <= CS_MODE_APPR;
            idx_q       <= '0;
            xappr_q     <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            // y is deliberately kept; only the window and handshake are flushed.
            state_q     <= ST_IDLE;
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 1; i < N; i++) win_q[i] <= win_q[i-1];
                        win_q[0] <= bus.x;
                        sum_q    <= sum_q - SUM_W'(win_q[N-1]) + SUM_W'(bus.x);
                        mode_q   <= bus.mode;
                        state_q  <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        idx_q   <= '0;
                        xappr_q <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if ((SUM_W'(tap) <= avg) && (tap > xappr_q)) begin
                        xappr_q <= tap;
                    end
                    if (idx_q == IW'(N - 1)) begin
                        state_q <= ST_CALC;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_CALC: begin
                    y_q         <= y_calc;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;

endmodule
